// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle for the UART RX frame controller.
//   RX_IN      : synchronized serial input, idle high
//   PAR_EN     : parity bit present (quasi-static)
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   bit_cnt    : bit index from the edge/bit counter
//   edge_cnt   : oversampling edge index within the bit
//   cnt_en     : counter enable; the counter clears while low
//   P_DATA     : last good received byte
//   data_valid : one-cycle strobe when P_DATA updates
//   par_err    : parity error of the current/last frame
//   stp_err    : stop-bit error of the current/last frame
// master = frame controller side, slave = line/counter/consumer side.
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned CNT_W = 5;

  logic              RX_IN;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              cnt_en;
  logic [DATA_W-1:0] P_DATA;
  logic              data_valid;
  logic              par_err;
  logic              stp_err;

  modport master (
    input  RX_IN,
    input  PAR_EN,
    input  PAR_TYP,
    input  bit_cnt,
    input  edge_cnt,
    output cnt_en,
    output P_DATA,
    output data_valid,
    output par_err,
    output stp_err
  );

  modport slave (
    output RX_IN,
    output PAR_EN,
    output PAR_TYP,
    output bit_cnt,
    output edge_cnt,
    input  cnt_en,
    input  P_DATA,
    input  data_valid,
    input  par_err,
    input  stp_err
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Drives the enable of the external edge/bit
// counter, takes three mid-bit samples per bit and resolves them by majority,
// deserializes DATA_W bits LSB first, checks optional parity and the stop
// bit, and presents a good byte with a one-cycle data_valid strobe.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_rx_frame_ctrl_if.master (RX_IN, PAR_EN, PAR_TYP, bit_cnt,
//         edge_cnt in; cnt_en, P_DATA, data_valid, par_err, stp_err out)
module uart_rx_frame_ctrl #(
  parameter int unsigned PRESCALE = 8,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_rx_frame_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 5;

  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] EDGE_MID  = CNT_W'(PRESCALE / 2);
  localparam logic [CNT_W-1:0] EDGE_S0   = CNT_W'(PRESCALE / 2 - 1);
  localparam logic [CNT_W-1:0] EDGE_S2   = CNT_W'(PRESCALE / 2 + 1);
  localparam logic [CNT_W-1:0] BIT_DATA_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] BIT_STOP_NOPAR = CNT_W'(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        samp;
  logic [2:0]        samp_nxt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] p_data_nxt;
  logic              valid_nxt;
  logic              par_nxt;
  logic              stp_nxt;
  logic              maj;
  logic              last;

  // Counter runs whenever a frame is in progress.
  assign bus.cnt_en = (state != ST_IDLE);

  assign last = (bus.edge_cnt == EDGE_LAST);
  assign maj  = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  // Next-state, sampling and output decode.
  always_comb begin
    state_nxt  = state;
    samp_nxt   = samp;
    shift_nxt  = shift_q;
    p_data_nxt = bus.P_DATA;
    valid_nxt  = 1'b0;
    par_nxt    = bus.par_err;
    stp_nxt    = bus.stp_err;

    // Three consecutive samples straddling the bit centre.
    if (state != ST_IDLE) begin
      if (bus.edge_cnt == EDGE_S0)  samp_nxt[0] = bus.RX_IN;
      if (bus.edge_cnt == EDGE_MID) samp_nxt[1] = bus.RX_IN;
      if (bus.edge_cnt == EDGE_S2)  samp_nxt[2] = bus.RX_IN;
    end

    case (state)
      ST_IDLE: begin
        if (!bus.RX_IN) begin
          state_nxt = ST_START;
          par_nxt   = 1'b0;
          stp_nxt   = 1'b0;
          shift_nxt = '0;
        end
      end

      ST_START: begin
        // A start bit that does not hold low at mid-bit is a glitch.
        if (last) state_nxt = maj ? ST_IDLE : ST_DATA;
      end

      ST_DATA: begin
        if (last) begin
          for (int i = 0; i < int'(DATA_W); i++) begin
            if (bus.bit_cnt == CNT_W'(i + 1)) shift_nxt[i] = maj;
          end
          if (bus.bit_cnt == BIT_DATA_LAST) state_nxt = bus.PAR_EN ? ST_PARITY : ST_STOP;
        end
      end

      ST_PARITY: begin
        if (last) begin
          par_nxt   = maj ^ (^shift_q ^ bus.PAR_TYP);
          state_nxt = ST_STOP;
        end
      end

      ST_STOP: begin
        if (last) begin
          stp_nxt = ~maj;
          // Deliver only when both the stop bit and parity are good.
          if (maj && !(bus.PAR_EN && bus.par_err)) begin
            p_data_nxt = shift_q;
            valid_nxt  = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      samp           <= '0;
      shift_q        <= '0;
      bus.P_DATA     <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      samp           <= samp_nxt;
      shift_q        <= shift_nxt;
      bus.P_DATA     <= p_data_nxt;
      bus.data_valid <= valid_nxt;
      bus.par_err    <= par_nxt;
      bus.stp_err    <= stp_nxt;
    end
  end

  // The counter must never run past the stop bit while a frame is active.
  a_bit_cnt_range: assert property (@(posedge clk) disable iff (rst)
    (state != ST_IDLE) |-> (bus.bit_cnt <= BIT_STOP_NOPAR + CNT_W'(bus.PAR_EN)));

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the edge/bit counter, drives serial
// frames, and predicts outputs from frame contents and line timing.
module tb_uart_rx_frame_ctrl;

  localparam int PRESCALE = 8;
  localparam int DATA_W   = 8;
  localparam int NB_BASE  = DATA_W + 2;

  typedef enum int {EV_CLR, EV_PAR, EV_STOP, EV_OFF, EV_RST} ev_kind_t;
  typedef struct {
    int          cyc;
    ev_kind_t    kind;
    logic [7:0]  data;
    logic        flag;
    logic        good;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] vdata_q[$];

  logic clk = 1'b0;
  logic rst;
  logic rx_line;
  logic glitch_en;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_on = 1'b0;
  int   idle_from = 0;
  int   valid_cnt = 0;
  int   last_valid = -1;
  int   last_rise = -1;
  logic prev_en = 1'b0;

  logic       exp_cnt_en, exp_valid, exp_par, exp_stp;
  logic [7:0] exp_pdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_ctrl_if #(.DATA_W(DATA_W)) bus ();

  uart_rx_frame_ctrl #(
    .PRESCALE(PRESCALE),
    .DATA_W  (DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Edge/bit counter companion block.
  always @(posedge clk) begin
    if (!bus.cnt_en) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= '0;
    end else if (bus.edge_cnt == 5'(PRESCALE - 1)) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= bus.bit_cnt + 5'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 5'd1;
    end
  end

  // Optional one-cycle inversion at the centre of data bit 3.
  assign bus.RX_IN = rx_line ^ (glitch_en && bus.cnt_en &&
                                bus.bit_cnt == 5'd3 && bus.edge_cnt == 5'(PRESCALE / 2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(int c, ev_kind_t k, logic [7:0] d, logic f, logic g);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = d; e.flag = f; e.good = g;
    ev_q.push_back(e);
  endfunction

  // Frame whose start bit is on the line from edge s: the receiver accepts it
  // at the first edge it is idle and the line is low, then each bit takes
  // PRESCALE cycles; results appear the cycle after the last bit ends.
  function automatic void model_frame(int s, bit fs, logic [7:0] d, bit pen, bit ptyp,
                                      bit pbit, bit stopb);
    int det  = (s > idle_from) ? s : idle_from;
    int nb   = fs ? 1 : NB_BASE + (pen ? 1 : 0);
    int fin  = det + PRESCALE * nb;
    bit perr = pen && (pbit != ((^d) ^ ptyp));
    push_ev(det, EV_CLR, 8'h00, 1'b0, 1'b0);
    if (!fs && pen) push_ev(det + PRESCALE * NB_BASE, EV_PAR, 8'h00, perr, 1'b0);
    if (fs) push_ev(fin, EV_OFF, 8'h00, 1'b0, 1'b0);
    else    push_ev(fin, EV_STOP, d, !stopb, stopb && !perr);
    idle_from = fin + 1;
  endfunction

  function automatic void model_reset(int r);
    while (ev_q.size() > 0 && ev_q[ev_q.size()-1].cyc >= r) void'(ev_q.pop_back());
    push_ev(r, EV_RST, 8'h00, 1'b0, 1'b0);
    idle_from = r + 1;
  endfunction

  // Per-cycle compare against the model plus an activity monitor.
  always @(negedge clk) begin
    ev_t e;
    if (chk_on) begin
      exp_valid = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
        e = ev_q.pop_front();
        case (e.kind)
          EV_CLR:  begin exp_par = 1'b0; exp_stp = 1'b0; exp_cnt_en = 1'b1; end
          EV_PAR:  exp_par = e.flag;
          EV_STOP: begin
            exp_stp    = e.flag;
            exp_cnt_en = 1'b0;
            if (e.good) begin exp_valid = 1'b1; exp_pdata = e.data; end
          end
          EV_OFF:  exp_cnt_en = 1'b0;
          default: begin
            exp_cnt_en = 1'b0; exp_par = 1'b0; exp_stp = 1'b0; exp_pdata = 8'h00;
          end
        endcase
      end
      check("cnt_en",     bus.cnt_en,     exp_cnt_en);
      check("data_valid", bus.data_valid, exp_valid);
      check("P_DATA",     bus.P_DATA,     exp_pdata);
      check("par_err",    bus.par_err,    exp_par);
      check("stp_err",    bus.stp_err,    exp_stp);
      if (bus.data_valid) begin
        valid_cnt++;
        last_valid = cyc;
        vdata_q.push_back(bus.P_DATA);
      end
      if (bus.cnt_en && !prev_en) last_rise = cyc;
      prev_en = bus.cnt_en;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_line = 1'b1;
      rst     = 1'b0;
    end
  endtask

  // Values set at a falling edge are sampled at the next rising edge (cyc+1).
  task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stopb,
                            input int gpos, input int rst_off);
    bit          pen  = bus.PAR_EN;
    bit          ptyp = bus.PAR_TYP;
    int          nb   = NB_BASE + (pen ? 1 : 0);
    logic [15:0] bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) bits[i+1] = d[i];
    if (pen) bits[DATA_W+1] = pbit;
    bits[nb-1] = stopb;
    for (int k = 0; k < nb * PRESCALE; k++) begin
      @(negedge clk);
      if (k == 0) model_frame(cyc + 1, 1'b0, d, pen, ptyp, pbit, stopb);
      rx_line = bits[k / PRESCALE] ^ (k == gpos);
      if (k == rst_off) begin
        rst = 1'b1;
        model_reset(cyc + 1);
      end else begin
        rst = 1'b0;
      end
    end
  endtask

  task automatic false_start();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) model_frame(cyc + 1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      rx_line = 1'b0;
    end
    idle(PRESCALE + 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int         v0;
    logic [7:0] d;
    bit         pbit, stopb;
    int         gpos;

    rst = 1'b1; rx_line = 1'b1; glitch_en = 1'b0;
    bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    exp_cnt_en = 1'b0; exp_valid = 1'b0; exp_par = 1'b0; exp_stp = 1'b0; exp_pdata = 8'h00;
    chk_on = 1'b1;
    rst = 1'b0;
    idle(5);

    // 0xA5, no parity
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
    idle(6);
    check("a5_valid_count", valid_cnt - v0, 1);
    check("a5_latency", last_valid - last_rise, 80);
    check("a5_pdata", bus.P_DATA, 8'hA5);
    check("a5_flags", {bus.par_err, bus.stp_err}, 2'b00);

    // Even parity: good then bad parity bit
    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    idle(2);
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    idle(6);
    check("par_good_latency", last_valid - last_rise, 88);
    check("par_good_pdata", bus.P_DATA, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    idle(6);
    check("par_bad_flag", bus.par_err, 1'b1);
    check("par_bad_pdata", bus.P_DATA, 8'h3C);
    check("par_valid_count", valid_cnt - v0, 1);

    // False start clears flags and delivers nothing
    bus.PAR_EN = 1'b0;
    idle(2);
    v0 = valid_cnt;
    false_start();
    idle(10);
    check("fs_flags", {bus.par_err, bus.stp_err}, 2'b00);
    check("fs_cnt_en", bus.cnt_en, 1'b0);
    check("fs_valid_count", valid_cnt - v0, 0);

    // Bad stop bit, then a good frame
    send_frame(8'h81, 1'b0, 1'b0, -1, -1);
    idle(6);
    check("stp_bad_flag", bus.stp_err, 1'b1);
    check("stp_bad_valid_count", valid_cnt - v0, 0);
    send_frame(8'h7E, 1'b0, 1'b1, -1, -1);
    idle(6);
    check("recover_pdata", bus.P_DATA, 8'h7E);
    check("recover_stp", bus.stp_err, 1'b0);

    // Back-to-back frames with a mid-bit glitch in each
    glitch_en = 1'b1;
    v0 = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b1, -1, -1);
    send_frame(8'hAA, 1'b0, 1'b1, -1, -1);
    idle(6);
    glitch_en = 1'b0;
    check("b2b_valid_count", valid_cnt - v0, 2);
    check("b2b_first", vdata_q[vdata_q.size()-2], 8'h55);
    check("b2b_second", vdata_q[vdata_q.size()-1], 8'hAA);

    // Reset in the middle of bit_cnt 4, then a clean frame
    v0 = valid_cnt;
    send_frame(8'hFB, 1'b0, 1'b1, -1, PRESCALE * 4 + 3);
    idle(6);
    check("rst_pdata", bus.P_DATA, 8'h00);
    check("rst_valid_count", valid_cnt - v0, 0);
    send_frame(8'h12, 1'b0, 1'b1, -1, -1);
    idle(6);
    check("post_rst_pdata", bus.P_DATA, 8'h12);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      idle(2);
      bus.PAR_EN  = 1'($urandom_range(0, 1));
      bus.PAR_TYP = 1'($urandom_range(0, 1));
      idle(int'($urandom_range(1, 5)));
      if ($urandom_range(0, 9) == 0) begin
        false_start();
      end else begin
        d     = 8'($urandom);
        pbit  = (^d) ^ bus.PAR_TYP ^ ($urandom_range(0, 3) == 0);
        stopb = ($urandom_range(0, 9) != 0);
        gpos  = ($urandom_range(0, 1) == 1) ?
                int'($urandom_range(PRESCALE, PRESCALE * (DATA_W + 1) - 1)) : -1;
        send_frame(d, pbit, stopb, gpos, -1);
      end
    end

    idle(20);
    check("events_drained", ev_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
